// File: rtl/status_stack_reg.sv
// status_stack_reg: N-bit status flag register with a DEPTH-entry LIFO
// shadow stack. Flags can be partially updated under a bit mask, saved
// (push), restored (pop) or swapped with the top entry (push+pop).
// Over/underflow attempts set sticky error flags that never block work.
// All state changes happen on the falling edge of clk; rst is async.
module status_stack_reg #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in,
    input  logic          s,
    input  logic [N-1:0]  mask,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic [N-1:0]  out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err
);

    // Architectural state and its next-state values
    logic [N-1:0]  out_q;
    logic [N-1:0]  out_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;
    logic [N-1:0]  stack_q [DEPTH];

    // Single stack write port shared by push and exchange
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic [N-1:0]  wr_data;

    // Decoded helpers
    logic          full_w;
    logic          empty_w;
    logic [CW-1:0] top_idx;
    logic [N-1:0]  top_val;
    logic [N-1:0]  upd_val;
    logic          ovf_set;
    logic          unf_set;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Index of the most recent entry; only meaningful when not empty
    assign top_idx = count_q - CW'(1);

    // Masked flag update: written bits take in, others keep their value
    assign upd_val = (in & mask) | (out_q & ~mask);

    // Read mux for the top-of-stack entry; compares against the count-width
    // index so no out-of-range array access is ever generated
    always_comb begin
        top_val = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (top_idx == CW'(k)) begin
                top_val = stack_q[k];
            end
        end
    end

    // Command decode: exchange / pop / push / underflow / plain update.
    // A pop that finds data wins over s; a pop on an empty stack combined
    // with push degrades to a plain push and raises no underflow.
    always_comb begin
        out_d   = out_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = count_q;
        wr_data = out_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (pop && !empty_w) begin
            out_d = top_val;
            if (push) begin
                // Exchange: top entry and current flags swap places
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                count_d = count_q - CW'(1);
            end
        end else if (push) begin
            // Pushed value is the pre-update flags; update still applies
            if (s) begin
                out_d = upd_val;
            end
            if (full_w) begin
                ovf_set = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = count_q;
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            // Pop on empty stack: nothing moves, s is ignored
            unf_set = 1'b1;
        end else if (s) begin
            out_d = upd_val;
        end
    end

    // Sticky error flags: a new error on this edge beats clr_err
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        unf_d = unf_set | (unf_q & ~clr_err);
    end

    // Flag register, occupancy count and error flags
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack entries as individual registers so reset can clear them all
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
            logic entry_we;
            assign entry_we = wr_en && (wr_idx == CW'(gi));

            // One stack entry, written when the shared port targets it
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    stack_q[gi] <= '0;
                end else if (entry_we) begin
                    stack_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign out     = out_q;
    assign count   = count_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_status_stack_reg.sv
// Directed testbench for status_stack_reg (N=4, DEPTH=4). Inputs change
// just after the rising edge; the DUT acts on the falling edge; outputs
// are checked just after the following rising edge.
module tb_status_stack_reg;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [N-1:0]  in;
    logic          s;
    logic [N-1:0]  mask;
    logic          push;
    logic          pop;
    logic          clr_err;
    logic [N-1:0]  out;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;

    int n_cmp;
    int n_err;

    status_stack_reg #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .s       (s),
        .mask    (mask),
        .push    (push),
        .pop     (pop),
        .clr_err (clr_err),
        .out     (out),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance through one falling (update) edge to just past the next rising edge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Apply one command for exactly one update edge
    task automatic drive(input logic s_v, input logic [N-1:0] in_v, input logic [N-1:0] mask_v,
                         input logic push_v, input logic pop_v, input logic clr_v);
        s       = s_v;
        in      = in_v;
        mask    = mask_v;
        push    = push_v;
        pop     = pop_v;
        clr_err = clr_v;
        tick();
        s = 0; in = '0; mask = '0; push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic expect_state(input string tag, input logic [N-1:0] o, input int c,
                                input logic ov, input logic un);
        check_val({tag, ".out"},   32'(out),     32'(o));
        check_val({tag, ".count"}, 32'(count),   32'(c));
        check_val({tag, ".full"},  32'(full),    32'(c == DEPTH));
        check_val({tag, ".empty"}, 32'(empty),   32'(c == 0));
        check_val({tag, ".ovf"},   32'(ovf_err), 32'(ov));
        check_val({tag, ".unf"},   32'(unf_err), 32'(un));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        // Reset with active-looking inputs, which must be ignored
        rst = 1; s = 1; in = 4'b1111; mask = 4'b1111; push = 1; pop = 0; clr_err = 0;
        tick();
        tick();
        expect_state("reset", 4'b0000, 0, 0, 0);
        s = 0; in = '0; mask = '0; push = 0;
        rst = 0;

        // Masked update
        drive(1, 4'b1111, 4'b1010, 0, 0, 0);
        check_val("mask1.out", 32'(out), 32'b1010);
        drive(1, 4'b0000, 4'b0010, 0, 0, 0);
        check_val("mask2.out", 32'(out), 32'b1000);
        // No command: hold
        drive(0, 4'b1111, 4'b1111, 0, 0, 0);
        expect_state("hold", 4'b1000, 0, 0, 0);

        // Push with simultaneous update, then pop
        drive(1, 4'b1001, 4'b1111, 0, 0, 0);
        check_val("set1001.out", 32'(out), 32'b1001);
        drive(1, 4'b0110, 4'b1111, 1, 0, 0);
        expect_state("pushupd", 4'b0110, 1, 0, 0);
        drive(1, 4'b1111, 4'b1111, 0, 1, 0);
        expect_state("pop1", 4'b1001, 0, 0, 0);

        // Fill to DEPTH, then overflow
        drive(1, 4'b0001, 4'b1111, 1, 0, 0);
        expect_state("push1", 4'b0001, 1, 0, 0);
        drive(1, 4'b0010, 4'b1111, 1, 0, 0);
        drive(1, 4'b0011, 4'b1111, 1, 0, 0);
        drive(1, 4'b0100, 4'b1111, 1, 0, 0);
        expect_state("push4", 4'b0100, 4, 0, 0);
        drive(1, 4'b0101, 4'b1111, 1, 0, 0);
        expect_state("push5ovf", 4'b0101, 4, 1, 0);
        // Overflow again while clearing: set wins
        drive(0, 4'b0000, 4'b0000, 1, 0, 1);
        expect_state("ovfclr", 4'b0101, 4, 1, 0);
        // LIFO restore
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("pop_a", 4'b0011, 3, 1, 0);
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("pop_b", 4'b0010, 2, 1, 0);
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("pop_c", 4'b0001, 1, 1, 0);
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("pop_d", 4'b1001, 0, 1, 0);
        drive(0, 4'b0000, 4'b0000, 0, 0, 1);
        expect_state("clr", 4'b1001, 0, 0, 0);

        // Underflow after reset; s ignored
        rst = 1;
        tick();
        rst = 0;
        drive(1, 4'b1111, 4'b1111, 0, 1, 0);
        expect_state("unf", 4'b0000, 0, 0, 1);
        drive(0, 4'b0000, 4'b0000, 0, 1, 1);
        expect_state("unfclr", 4'b0000, 0, 0, 1);
        drive(0, 4'b0000, 4'b0000, 0, 0, 1);
        expect_state("unfclr2", 4'b0000, 0, 0, 0);

        // Push+pop while empty acts as push with update
        drive(1, 4'b0011, 4'b1111, 1, 1, 0);
        expect_state("pp_empty", 4'b0011, 1, 0, 0);
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("pp_pop", 4'b0000, 0, 0, 0);

        // Exchange
        drive(1, 4'b0011, 4'b1111, 0, 0, 0);
        drive(0, 4'b0000, 4'b0000, 1, 0, 0);
        expect_state("xpush", 4'b0011, 1, 0, 0);
        drive(1, 4'b1100, 4'b1111, 0, 0, 0);
        drive(1, 4'b1111, 4'b1111, 1, 1, 0);
        expect_state("xchg", 4'b0011, 1, 0, 0);
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("xtop", 4'b1100, 0, 0, 0);

        // Async reset mid-sequence with three entries stacked
        drive(0, 4'b0000, 4'b0000, 1, 0, 0);
        drive(0, 4'b0000, 4'b0000, 1, 0, 0);
        drive(1, 4'b0101, 4'b1111, 1, 0, 0);
        expect_state("pre_rst", 4'b0101, 3, 0, 0);
        #2 rst = 1;
        #1;
        expect_state("async_rst", 4'b0000, 0, 0, 0);
        tick();
        rst = 0;
        drive(0, 4'b0000, 4'b0000, 0, 1, 0);
        expect_state("post_rst_pop", 4'b0000, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/status_stack_reg.md
STATUS_STACK_REG -- requirements
Module: status_stack_reg

Interface
REQ-001 SHALL provide parameter N, default 4, width of the status flag word (N >= 1).
REQ-002 SHALL provide parameter DEPTH, default 4, number of shadow-stack entries (DEPTH >= 1).
REQ-003 SHALL define CW = $clog2(DEPTH+1), the width of the occupancy count.
REQ-004 SHALL have port clk  input  1  clock; all state updates on falling edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in  input  N  new flag values.
REQ-007 SHALL have port s  input  1  flag update enable.
REQ-008 SHALL have port mask  input  N  per-bit write enable for update; 1 = bit written.
REQ-009 SHALL have port push  input  1  save current flags to shadow stack.
REQ-010 SHALL have port pop  input  1  restore flags from shadow stack.
REQ-011 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-012 SHALL have port out  output  N  current flag register.
REQ-013 SHALL have port count  output  CW  number of valid stack entries.
REQ-014 SHALL have port full  output  1  count == DEPTH (combinational from count).
REQ-015 SHALL have port empty  output  1  count == 0 (combinational from count).
REQ-016 SHALL have port ovf_err  output  1  sticky: push attempted while full.
REQ-017 SHALL have port unf_err  output  1  sticky: pop attempted while empty.

Function
REQ-018 SHALL sample all inputs and update all registers only on the falling edge of clk; outputs valid one falling edge after inputs (latency 1).
REQ-019 Update only (s=1, push=0, pop=0): out[i] <= mask[i] ? in[i] : out[i] for each bit i.
REQ-020 No command (s=0, push=0, pop=0): out, stack, and count hold.
REQ-021 Push only, not full: stack[count] <= out (value before this edge); count <= count+1.
REQ-022 Push with s=1: pushed value is the pre-update out; out simultaneously takes the masked update.
REQ-023 Push while full: stack and count unchanged, ovf_err <= 1, any s update still applied to out.
REQ-024 Pop only, not empty: out <= stack[count-1]; count <= count-1; s ignored on that edge.
REQ-025 Pop while empty: out, stack, and count unchanged, unf_err <= 1, s ignored on that edge.
REQ-026 Push and pop on the same edge, not empty (exchange): out <= stack[count-1], stack[count-1] <= old out; count unchanged; s ignored; no error.
REQ-027 Push and pop on the same edge while empty: treated as push only (REQ-021/022 apply); unf_err not set.
REQ-028 Stack SHALL be LIFO; entries at index >= count are don't-care and never drive out.
REQ-029 clr_err=1 clears ovf_err and unf_err; a set condition on the same edge takes priority (flag ends 1).
REQ-030 Error flags remain set until clr_err or rst; they do not block further operations.
REQ-031 count SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-032 rst=1 SHALL immediately, independent of clk, force out=0, count=0, all stack entries=0, ovf_err=0, unf_err=0; hence empty=1, full=0.
REQ-033 While rst=1, all inputs ignored; first update occurs on the first falling edge after rst deasserts.
REQ-034 rst asserted mid-sequence (stack partially filled) SHALL discard all stacked contents.

Verification
REQ-035 Masked update: out=0000, s=1, in=1111, mask=1010 -> out=1010; then in=0000, mask=0010 -> out=1000.
REQ-036 Push/update/pop: out=1001, push=1 and s=1 with in=0110, mask=1111 -> out=0110, count=1; pop=1 -> out=1001, count=0, empty=1.
REQ-037 Overflow (DEPTH=4): 5 consecutive pushes -> count=4, full=1, ovf_err=1 after 5th; 4 pops restore values in reverse order; clr_err -> ovf_err=0.
REQ-038 Underflow: after reset, pop=1 with s=1, in=1111 -> out=0000, unf_err=1, count=0.
REQ-039 Exchange: push 0011, set out=1100, push=1 and pop=1 -> out=0011, top entry=1100, count=1.
REQ-040 Async reset: count=3, out=0101, rst pulsed between clock edges -> out=0000, count=0, errors 0 before next edge.
